// File: rtl/main_memory_ctrl.sv
// Single-port data memory with valid/ready request/response, byte-enable writes,
// alignment/range error responses and a configurable read latency.
// Optional MAIN_MEM_PERF_CNT_EN adds completed read/write counters.
module main_memory_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqWrite,
  input  logic [ADDR_WIDTH-1:0]   reqAddr,
  input  logic [DATA_WIDTH/8-1:0] reqByteEn,
  input  logic [DATA_WIDTH-1:0]   dataIn,
  output logic                    respValid,
  input  logic                    respReady,
  output logic                    respError,
  output logic [DATA_WIDTH-1:0]   dataOut,
  output logic [31:0]             readCount,
  output logic [31:0]             writeCount,
  output logic [1:0]              dbgState
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int B     = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int HI    = B + DEPTH_LOG2;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Handshake contract: a request transfers on a clk edge where reqValid & reqReady;
  // a response retires on a clk edge where respValid & respReady. Exactly one is in flight.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t                  r_state;
  logic                    r_req_ready;
  logic                    r_resp_valid;
  logic                    r_resp_err;
  logic [DATA_WIDTH-1:0]   r_data_out;
  logic [3:0]              r_cnt;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

  logic                    w_misaligned;
  logic                    w_out_of_range;
  logic                    w_err;
  logic                    w_hs;
  logic                    w_wr_commit;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic [3:0]              w_cnt_next;

  generate
    if (B == 0) begin : g_no_align
      assign w_misaligned = 1'b0;
    end else begin : g_align
      assign w_misaligned = |reqAddr[B-1:0];
    end
    if (HI >= ADDR_WIDTH) begin : g_no_range
      assign w_out_of_range = 1'b0;
    end else begin : g_range
      assign w_out_of_range = |reqAddr[ADDR_WIDTH-1:HI];
    end
  endgenerate

  assign w_idx       = reqAddr[HI-1:B];
  assign w_err       = w_misaligned | w_out_of_range;
  assign w_hs        = reqValid & r_req_ready;
  assign w_wr_commit = rstN & w_hs & reqWrite & ~w_err;
  assign w_cnt_next  = r_cnt - 4'd1;

  // Array is never reset; a committed write survives a later reset.
  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      for (int i = 0; i < BE_W; i++) begin
        if (reqByteEn[i]) r_mem[w_idx][8*i +: 8] <= dataIn[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_data_out   <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_hs) begin
            r_req_ready <= 1'b0;
            r_idx       <= w_idx;
            if (w_err || reqWrite) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_err;
              r_data_out   <= '0;
              r_state      <= S_RESP;
            end else if (READ_LATENCY == 1) begin
              r_resp_valid <= 1'b1;
              r_data_out   <= r_mem[w_idx];
              r_state      <= S_RESP;
            end else begin
              r_cnt   <= 4'(READ_LATENCY - 1);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_next;
          if (w_cnt_next == 4'd0) begin
            r_data_out   <= r_mem[r_idx];
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (respReady) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_data_out   <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAIN_MEM_PERF_CNT_EN
  logic        r_is_write;
  logic [31:0] r_read_count;
  logic [31:0] r_write_count;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_is_write    <= 1'b0;
      r_read_count  <= '0;
      r_write_count <= '0;
    end else begin
      if (w_hs) r_is_write <= reqWrite;
      if (r_state == S_RESP && respReady && !r_resp_err) begin
        if (r_is_write) r_write_count <= r_write_count + 32'd1;
        else            r_read_count  <= r_read_count + 32'd1;
      end
    end
  end

  assign readCount  = r_read_count;
  assign writeCount = r_write_count;
`else
  assign readCount  = 32'd0;
  assign writeCount = 32'd0;
`endif

  assign reqReady  = r_req_ready;
  assign respValid = r_resp_valid;
  assign respError = r_resp_err;
  assign dataOut   = r_data_out;
  assign dbgState  = r_state;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl (32-bit data, 1024 words, read latency 2)
// with a scoreboard queue of expected responses and a reference word model.
module tb_main_memory_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DL2 = 10;
  localparam int RL  = 2;

  logic          clk;
  logic          rstN;
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [AW-1:0] reqAddr;
  logic [3:0]    reqByteEn;
  logic [DW-1:0] dataIn;
  logic          respValid;
  logic          respReady;
  logic          respError;
  logic [DW-1:0] dataOut;
  logic [31:0]   readCount;
  logic [31:0]   writeCount;
  logic [1:0]    dbgState;

  main_memory_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL2), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqAddr(reqAddr), .reqByteEn(reqByteEn), .dataIn(dataIn),
    .respValid(respValid), .respReady(respReady), .respError(respError),
    .dataOut(dataOut), .readCount(readCount), .writeCount(writeCount),
    .dbgState(dbgState)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {is_write, error, data} and expected latency
  logic [33:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] mdl [0:1023];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_rd   = 0;
  int          n_wr   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: compute expectation, push it, present the request
  task automatic prep(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be);
    logic        err;
    logic [31:0] exp_d;
    logic [9:0]  idx;
    err   = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
    idx   = addr[11:2];
    exp_d = 32'd0;
    if (!err && !wr) exp_d = mdl[idx];
    if (!err && wr) begin
      for (int i = 0; i < 4; i++) if (be[i]) mdl[idx][8*i +: 8] = data[8*i +: 8];
    end
    exp_q.push_back({wr, err, exp_d});
    lat_q.push_back((err || wr) ? 1 : RL);
    reqValid  = 1'b1;
    reqWrite  = wr;
    reqAddr   = addr;
    reqByteEn = be;
    dataIn    = data;
  endtask

  task automatic wait_hs();
    int n;
    n = 0;
    while (!reqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("hs_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 reqValid = 1'b0;
  endtask

  task automatic await_resp(input int hold);
    int          lat;
    int          exp_lat;
    logic [33:0] e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!respValid && lat < 40);
    exp_lat = lat_q.pop_front();
    e       = exp_q.pop_front();
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("resp_error", {63'd0, respError}, {63'd0, e[32]});
    chk("resp_data", {32'd0, dataOut}, {32'd0, e[31:0]});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, respValid}, 64'd1);
      chk("hold_error", {63'd0, respError}, {63'd0, e[32]});
      chk("hold_data", {32'd0, dataOut}, {32'd0, e[31:0]});
      chk("hold_ready", {63'd0, reqReady}, 64'd0);
    end
    respReady = 1'b1;
    @(posedge clk);
    if (!e[32]) begin
      if (e[33]) n_wr++;
      else       n_rd++;
    end
    @(negedge clk);
    respReady = 1'b0;
    chk("retired_valid", {63'd0, respValid}, 64'd0);
    chk("retired_data", {32'd0, dataOut}, 64'd0);
    chk("retired_ready", {63'd0, reqReady}, 64'd1);
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] be);
    prep(wr, addr, data, be);
    wait_hs();
    await_resp(0);
  endtask

  initial begin
    logic [31:0] rd;
    rstN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0;
    reqByteEn = '0; dataIn = '0; respReady = 1'b0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, reqReady}, 64'd0);
    chk("rst_valid", {63'd0, respValid}, 64'd0);
    chk("rst_data", {32'd0, dataOut}, 64'd0);
    chk("rst_rdcnt", {32'd0, readCount}, 64'd0);
    chk("rst_wrcnt", {32'd0, writeCount}, 64'd0);
    rstN = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, reqReady}, 64'd1);
    chk("post_rst_valid", {63'd0, respValid}, 64'd0);

    // Basic write / read / byte enables
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    txn(1'b0, 32'h10, 32'h0, 4'h0);
    txn(1'b1, 32'h10, 32'h11223344, 4'h5);
    txn(1'b0, 32'h10, 32'h0, 4'h0);
    chk("byteen_model", {32'd0, mdl[4]}, 64'hDE22BE44);

    // Errors: out-of-range write leaves word 0 intact, misaligned read
    txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    txn(1'b1, 32'h1000, 32'h55555555, 4'hF);
    txn(1'b0, 32'h0, 32'h0, 4'h0);
    txn(1'b0, 32'h13, 32'h0, 4'h0);
    txn(1'b0, 32'h8000_0000, 32'h0, 4'h0);

    // Zero byte-enable write, then top word boundary
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
    txn(1'b0, 32'h10, 32'h0, 4'h0);
    txn(1'b1, 32'hFFC, 32'h0BADF00D, 4'hF);
    txn(1'b0, 32'hFFC, 32'h0, 4'h0);

    // Random data / byte enables over a small window
    for (int k = 0; k < 8; k++) txn(1'b1, 32'(32'h80 + 4*k), $urandom, 4'hF);
    for (int k = 0; k < 8; k++) begin
      txn(1'b1, 32'(32'h80 + 4*k), $urandom, 4'($urandom_range(0, 15)));
      txn(1'b0, 32'(32'h80 + 4 * $urandom_range(0, 7)), 32'h0, 4'h0);
    end

    // Backpressure with a request held during the stall
    prep(1'b0, 32'h10, 32'h0, 4'h0);
    wait_hs();
    prep(1'b1, 32'h20, 32'h12345678, 4'hF);
    await_resp(5);
    wait_hs();
    await_resp(0);
    txn(1'b0, 32'h20, 32'h0, 4'h0);

    // Reset during WAIT aborts the read silently
    prep(1'b0, 32'hFFC, 32'h0, 4'h0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    wait_hs();
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {63'd0, respValid}, 64'd0);
    chk("midrst_ready", {63'd0, reqReady}, 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    n_rd = 0;
    n_wr = 0;
    @(negedge clk);
    chk("midrst_valid2", {63'd0, respValid}, 64'd0);
    chk("midrst_ready2", {63'd0, reqReady}, 64'd1);
    txn(1'b0, 32'hFFC, 32'h0, 4'h0);
    txn(1'b0, 32'h10, 32'h0, 4'h0);
    txn(1'b0, 32'h0, 32'h0, 4'h0);
    txn(1'b1, 32'h40, 32'hA5A5A5A5, 4'hF);
    txn(1'b1, 32'h44, 32'h5A5A5A5A, 4'h3);
    txn(1'b0, 32'h42, 32'h0, 4'h0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
`ifdef MAIN_MEM_PERF_CNT_EN
    chk("read_count", {32'd0, readCount}, 64'(n_rd));
    chk("write_count", {32'd0, writeCount}, 64'(n_wr));
`else
    chk("read_count_off", {32'd0, readCount}, 64'd0);
    chk("write_count_off", {32'd0, writeCount}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
